// File: rtl/alu_pkg.sv
// Shared constants for the mini_cpu ALU: flag bit positions within an NZCV
// vector and the per-stage slice width helper.
package alu_pkg;

    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit add with carry in/out; one instance resolves one
// pipeline stage's share of the carry chain.
module adder_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES registered
// slices, with NZCV flags produced alongside the result in the last stage.
module pipelined_add_sub
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             zero_flag,
    output logic             negative_flag
);

    localparam int SLICE = slice_width(WIDTH, STAGES);
    localparam int LAST  = STAGES - 1;

    if (WIDTH % STAGES != 0) begin : g_bad_width
        $error("pipelined_add_sub: WIDTH must be a multiple of STAGES");
    end

    // Handshake: a beat moves on an edge where valid & ready are both high.
    // The whole pipe advances together unless the output holds an unaccepted
    // result, so in_ready is simply the advance enable.
    logic en;
    assign en        = ~(out_valid & ~out_ready);
    assign in_ready  = en;

    // Registered state of each stage (operands travel with the op).
    logic [WIDTH-1:0] st_a [STAGES];
    logic [WIDTH-1:0] st_b [STAGES];
    logic [WIDTH-1:0] st_r [STAGES];
    logic             st_c [STAGES];
    logic             st_v [STAGES];
    logic [3:0]       flags_q;

    // What each stage sees at its input this cycle.
    logic [WIDTH-1:0] in_a  [STAGES];
    logic [WIDTH-1:0] in_b  [STAGES];
    logic [WIDTH-1:0] in_r  [STAGES];
    logic             in_c  [STAGES];
    logic             in_v  [STAGES];
    logic [WIDTH-1:0] nxt_r [STAGES];
    logic [SLICE-1:0] slice_sum  [STAGES];
    logic             slice_cout [STAGES];
    logic [3:0]       nxt_flags;

    always_comb begin
        in_a[0] = a;
        in_b[0] = sub ? ~b : b;
        in_r[0] = '0;
        in_c[0] = cin;
        in_v[0] = in_valid;
        for (int s = 1; s < STAGES; s++) begin
            in_a[s] = st_a[s-1];
            in_b[s] = st_b[s-1];
            in_r[s] = st_r[s-1];
            in_c[s] = st_c[s-1];
            in_v[s] = st_v[s-1];
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_slice
        adder_slice #(.W(SLICE)) u_add (
            .a    (in_a[s][s*SLICE +: SLICE]),
            .b    (in_b[s][s*SLICE +: SLICE]),
            .cin  (in_c[s]),
            .sum  (slice_sum[s]),
            .cout (slice_cout[s])
        );
    end

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            nxt_r[s] = in_r[s];
            nxt_r[s][s*SLICE +: SLICE] = slice_sum[s];
        end
        nxt_flags         = '0;
        nxt_flags[FLAG_N] = nxt_r[LAST][WIDTH-1];
        nxt_flags[FLAG_Z] = ~|nxt_r[LAST];
        nxt_flags[FLAG_C] = slice_cout[LAST];
        nxt_flags[FLAG_V] = (in_a[LAST][WIDTH-1] == in_b[LAST][WIDTH-1]) &
                            (nxt_r[LAST][WIDTH-1] != in_a[LAST][WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) begin
                st_a[s] <= '0;
                st_b[s] <= '0;
                st_r[s] <= '0;
                st_c[s] <= 1'b0;
                st_v[s] <= 1'b0;
            end
            flags_q <= '0;
        end else if (en) begin
            for (int s = 0; s < STAGES; s++) begin
                st_a[s] <= in_a[s];
                st_b[s] <= in_b[s];
                st_r[s] <= nxt_r[s];
                st_c[s] <= slice_cout[s];
                st_v[s] <= in_v[s];
            end
            flags_q <= nxt_flags;
        end
    end

    assign out_valid     = st_v[LAST];
    assign result        = st_r[LAST];
    assign negative_flag = flags_q[FLAG_N];
    assign zero_flag     = flags_q[FLAG_Z];
    assign carry_flag    = flags_q[FLAG_C];
    assign overflow_flag = flags_q[FLAG_V];

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined integer adder/subtractor for the mini_cpu ALU.
- Successor to the single-cycle 32-bit ripple adder; adds subtract mode, carry-in, and configurable width.
- Segments the carry chain across STAGES register stages so wide adds meet timing.
- Valid/ready handshake on both sides; produces full NZCV flags.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; each stage resolves SLICE = WIDTH/STAGES result bits; STAGES >= 1.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts the beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B+cin; 1 = A+~B+cin (pass cin=1 for a true A-B).
- cin  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum/difference modulo 2^WIDTH.
- carry_flag  output  1  carry out of the MSB (for subtract: 1 = no borrow).
- overflow_flag  output  1  signed overflow.
- zero_flag  output  1  result == 0.
- negative_flag  output  1  result[WIDTH-1].

Behaviour:
- Reset, when reset is high at a clock edge:
  - All stage valid bits clear; all data/flag registers clear.
  - out_valid=0, result=0, all flags=0.
  - In-flight operations are discarded.
  - in_ready=1 in the first cycle after reset deasserts.
- Stall and accept:
  - stall = out_valid & ~out_ready.
  - Pipeline advance enable en = ~stall; in_ready = en (combinational).
  - A beat is accepted when in_valid & in_ready.
  - When en=0 every stage register holds its value and outputs are held stable.
- Bubbles: empty stages are not collapsed; a bubble advances like data. Throughput is 1 op/cycle when out_ready=1.
- Latency: a beat accepted at edge k appears with out_valid=1 after edge k+STAGES-1, i.e. STAGES cycles from issue to visible result.
- Datapath:
  - At accept, b_eff = sub ? ~b : b.
  - Stage s (0..STAGES-1) ripples bits [s*SLICE +: SLICE] using the carry registered by stage s-1; stage 0 uses cin.
  - Unresolved higher operand slices travel down the pipe with the op; resolved lower result slices travel with it as well.
  - The carry between slices is registered; no combinational carry path spans two stages.
- Flags, computed in the final stage and registered with the result:
  - carry_flag = carry out of bit WIDTH-1.
  - overflow_flag = (a[W-1] == b_eff[W-1]) & (result[W-1] != a[W-1]).
  - zero_flag = ~|result; negative_flag = result[W-1].
- STAGES=1: degenerates to a single registered add with latency 1; the same handshake applies.
- Ordering: strictly in order; no reordering or dropping while reset=0.
- Simultaneous accept and output handshake in one cycle is legal; there is no dead cycle.
- in_valid while in_ready=0: the beat is not taken; the source must hold it.

Decomposition:
- Shared package alu_pkg:
  - Flag index constants FLAG_N/Z/C/V.
  - Localparam helper SLICE = WIDTH/STAGES.
- Natural sub-module: adder_slice.
  - Combinational SLICE-bit ripple (a, b, cin -> sum, cout).
  - Instantiated once per stage by generate.
- Elaboration check: WIDTH % STAGES == 0, otherwise $error.

Test Plan (WIDTH=32, STAGES=4, out_ready=1 unless stated):
- Carry and wrap: a=FFFFFFFF, b=00000001, sub=0, cin=0 -> result=00000000, C=1, V=0, Z=1, N=0, out_valid exactly 4 cycles after issue.
- Signed overflow, positive: a=7FFFFFFF, b=1 -> result=80000000, V=1, N=1, C=0. Then a=80000000, b=80000000 -> result=0, C=1, V=1, Z=1.
- Subtraction (sub=1, cin=1): a=5, b=7 -> result=FFFFFFFE, C=0, N=1, V=0. a=7, b=5 -> result=2, C=1. a=80000000, b=1 -> result=7FFFFFFF, V=1.
- Cross-slice carry chain: a=00FFFFFF, b=1 -> 01000000. a=0000FFFF, b=00010001 -> 00020000. Back-to-back issues every cycle return in order, one per cycle.
- Backpressure: stream 6 ops with out_ready=0 -> after 4 accepts in_ready=0 and result/flags are held stable; raise out_ready -> all 6 results drain in order with no loss or duplication.
- Reset mid-flight: issue 3 ops, assert reset for 1 cycle -> out_valid=0 and all outputs 0 the next cycle; none of the 3 results ever appears; the next op issued completes normally with latency 4.
